// File: rtl/uart_tx_core.sv
// Serialising UART transmitter: accepts one word per handshake and sends
// start, data LSB-first, optional parity and stop bits on tx_serial.
module uart_tx_core #(
  parameter int Word_Len     = 8,
  parameter int Clks_Per_Bit = 868,
  parameter int Parity       = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [Word_Len-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                tx_serial,
  output logic                tx_busy,
  output logic                tx_done,
  output logic [2:0]          fsm_state
);

  localparam int CNT_W = (Clks_Per_Bit > 1) ? $clog2(Clks_Per_Bit) : 1;
  localparam int IDX_W = $clog2(Word_Len);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              state;
  logic [Word_Len-1:0] shift_reg;
  logic                par_bit;
  logic [CNT_W-1:0]    bit_cnt;
  logic [IDX_W-1:0]    bit_idx;
  logic                bit_last;

  assign bit_last  = (bit_cnt == CNT_W'(Clks_Per_Bit - 1));
  assign fsm_state = state;

  // Handshake: a word transfers on a rising edge where tx_valid and tx_ready
  // are both 1. tx_ready is high only in IDLE; tx_valid may stay high and
  // tx_data is ignored whenever tx_ready is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_valid) begin
            shift_reg <= tx_data;
            par_bit   <= (Parity == 2) ? ~(^tx_data) : ^tx_data;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            state     <= S_START;
            tx_serial <= 1'b0;
            tx_ready  <= 1'b0;
            tx_busy   <= 1'b1;
          end
        end
        S_START: begin
          if (bit_last) begin
            bit_cnt   <= '0;
            state     <= S_DATA;
            tx_serial <= shift_reg[0];
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_last) begin
            bit_cnt   <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_idx == IDX_W'(Word_Len - 1)) begin
              bit_idx <= '0;
              if (Parity != 0) begin
                state     <= S_PARITY;
                tx_serial <= par_bit;
              end else begin
                state     <= S_STOP;
                tx_serial <= 1'b1;
              end
            end else begin
              // Registered line: present the next bit as the shift happens.
              bit_idx   <= bit_idx + 1'b1;
              tx_serial <= shift_reg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_last) begin
            bit_cnt   <= '0;
            state     <= S_STOP;
            tx_serial <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_last) begin
            bit_cnt  <= '0;
            state    <= S_IDLE;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          tx_serial <= 1'b1;
          tx_ready  <= 1'b1;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: three instances (no, even, odd parity) share one
// stimulus stream and are compared every cycle against a frame-level model.
module tb_uart_tx_core;

  localparam int W   = 8;
  localparam int CPB = 4;
  // Expected line state packed as {serial, busy, ready, done}
  localparam logic [3:0] IDLE_V = 4'b1010;
  localparam logic [3:0] DONE_V = 4'b1011;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;

  logic       tx_ready_w  [3];
  logic       tx_serial_w [3];
  logic       tx_busy_w   [3];
  logic       tx_done_w   [3];
  logic [2:0] fsm_state_w [3];

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  logic [3:0] exp_q [3][$];
  logic [3:0] cur_exp [3] = '{IDLE_V, IDLE_V, IDLE_V};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  uart_tx_core #(.Word_Len(W), .Clks_Per_Bit(CPB), .Parity(0)) u_none (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready_w[0]), .tx_serial(tx_serial_w[0]), .tx_busy(tx_busy_w[0]),
    .tx_done(tx_done_w[0]), .fsm_state(fsm_state_w[0]));
  uart_tx_core #(.Word_Len(W), .Clks_Per_Bit(CPB), .Parity(1)) u_even (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready_w[1]), .tx_serial(tx_serial_w[1]), .tx_busy(tx_busy_w[1]),
    .tx_done(tx_done_w[1]), .fsm_state(fsm_state_w[1]));
  uart_tx_core #(.Word_Len(W), .Clks_Per_Bit(CPB), .Parity(2)) u_odd (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready_w[2]), .tx_serial(tx_serial_w[2]), .tx_busy(tx_busy_w[2]),
    .tx_done(tx_done_w[2]), .fsm_state(fsm_state_w[2]));

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Instance i uses parity mode i. A frame is a list of bits, each held CPB
  // cycles, followed by one idle cycle carrying the done pulse.
  task automatic model_accept(input int i, input logic [7:0] d);
    logic [10:0] bits;
    int n;
    int ones;
    bits = '1;
    ones = 0;
    bits[0] = 1'b0;
    n = 1;
    for (int b = 0; b < W; b++) begin
      bits[n] = d[b];
      ones += int'(d[b]);
      n++;
    end
    if (i == 1) begin bits[n] = (ones % 2 == 1); n++; end
    if (i == 2) begin bits[n] = (ones % 2 == 0); n++; end
    bits[n] = 1'b1;
    n++;
    for (int k = 0; k < n; k++)
      for (int c = 0; c < CPB; c++)
        exp_q[i].push_back({bits[k], 1'b1, 1'b0, 1'b0});
    exp_q[i].push_back(DONE_V);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        if (tx_valid && cur_exp[i][1]) model_accept(i, tx_data);
        if (exp_q[i].size() > 0) cur_exp[i] = exp_q[i].pop_front();
        else cur_exp[i] = IDLE_V;
      end
    end
  end

  always @(negedge reset) begin
    for (int i = 0; i < 3; i++) begin
      exp_q[i].delete();
      cur_exp[i] = IDLE_V;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++)
        check($sformatf("line_u%0d@%0t", i, $time),
              {60'd0, tx_serial_w[i], tx_busy_w[i], tx_ready_w[i], tx_done_w[i]},
              {60'd0, cur_exp[i]});
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [43:0] wave(input logic [10:0] bits, input int n);
    logic [43:0] w;
    for (int c = 0; c < 44; c++) w[43-c] = (c / CPB < n) ? bits[c / CPB] : 1'b1;
    return w;
  endfunction

  task automatic send_capture(input logic [7:0] d, input int poke,
                              output logic [43:0] w0, output logic [43:0] w1,
                              output logic [43:0] w2, output logic rdy_seen);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
    rdy_seen = 1'b0;
    for (int c = 0; c < 44; c++) begin
      w0[43-c] = tx_serial_w[0];
      w1[43-c] = tx_serial_w[1];
      w2[43-c] = tx_serial_w[2];
      if (c < 40 && tx_ready_w[0]) rdy_seen = 1'b1;
      if (c == poke) tx_data = 8'hFF;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [43:0] w0, w1, w2;
    logic        rdy_seen;
    logic [10:0] bits;
    int          dones0, dones1, rise0_a, rise0_b, rise1_a, rise1_b;
    logic        prev_busy0, prev_busy1;

    // Reset values
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("rst_vals_u%0d", i),
            {60'd0, tx_serial_w[i], tx_busy_w[i], tx_ready_w[i], tx_done_w[i]}, {60'd0, IDLE_V});
    chk_en = 1'b1;
    reset  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_line", {63'd0, tx_serial_w[0]}, 64'd1);
    end

    // Single frame, no parity: 0x45
    send_capture(8'h45, -1, w0, w1, w2, rdy_seen);
    bits = 11'b00_1010001010;
    check("frame_45_none", {20'd0, w0}, {20'd0, wave(bits, 10)});

    // Even / odd parity: 0x46
    send_capture(8'h46, -1, w0, w1, w2, rdy_seen);
    bits = 11'b110_1000_1100;
    check("frame_46_even", {20'd0, w1}, {20'd0, wave(bits, 11)});
    bits = 11'b100_1000_1100;
    check("frame_46_odd", {20'd0, w2}, {20'd0, wave(bits, 11)});

    // Ignored input: data changes to 0xFF during DATA bit 1
    send_capture(8'h45, 9, w0, w1, w2, rdy_seen);
    bits = 11'b00_1010001010;
    check("frame_45_ignored", {20'd0, w0}, {20'd0, wave(bits, 10)});
    check("ready_low_in_frame", {63'd0, rdy_seen}, 64'd0);

    // Back-to-back with tx_valid held high
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h45;
    @(negedge clk);
    tx_data = 8'h46;
    dones0 = 0; dones1 = 0;
    rise0_a = -1; rise0_b = -1; rise1_a = -1; rise1_b = -1;
    prev_busy0 = 1'b0; prev_busy1 = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (tx_done_w[0]) dones0++;
      if (tx_done_w[1]) dones1++;
      if (tx_busy_w[0] && !prev_busy0) begin
        if (rise0_a < 0) rise0_a = c; else rise0_b = c;
      end
      if (tx_busy_w[1] && !prev_busy1) begin
        if (rise1_a < 0) rise1_a = c; else rise1_b = c;
      end
      prev_busy0 = tx_busy_w[0];
      prev_busy1 = tx_busy_w[1];
      if (c == 46) tx_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b_dones_none", 64'(dones0), 64'd2);
    check("b2b_dones_even", 64'(dones1), 64'd2);
    check("b2b_period_none", 64'(rise0_b - rise0_a), 64'd41);
    check("b2b_period_even", 64'(rise1_b - rise1_a), 64'd45);

    // Reset mid-frame during DATA bit 3 of 0x45
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h45;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1 check("bit3_before_rst", {63'd0, tx_serial_w[0]}, 64'd0);
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("async_rst_u%0d", i),
            {60'd0, tx_serial_w[i], tx_busy_w[i], tx_ready_w[i], tx_done_w[i]}, {60'd0, IDLE_V});
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    send_capture(8'h46, -1, w0, w1, w2, rdy_seen);
    bits = 11'b00_1010001100;
    check("frame_46_after_rst", {20'd0, w0}, {20'd0, wave(bits, 10)});
    bits = 11'b110_1000_1100;
    check("frame_46_even_after_rst", {20'd0, w1}, {20'd0, wave(bits, 11)});

    // Randomized traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
      end
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    repeat (60) @(negedge clk);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
